axi_lite_bram_ctrl_pipe: RTL and testbench
==========================================

// Module: axi_lite_bram_ctrl_pipe
// PURPOSE
//   AXI-lite slave to single-port BRAM controller for BRAMs with 1..3 cycles of read latency.
//   Pipelines reads with a credit-checked return FIFO, so it sustains one access per cycle.
//   Range-checks every address and returns SLVERR for accesses beyond BRAM_DEPTH.
//   Sits behind axi_to_lite, taking the place of axi_lite_bram_ctrl when output-registered BRAMs are used.
// PARAMETERS
//   ADDR_WIDTH       32                     AXI-lite address width
//   DATA_WIDTH       64                     data width; byte count DATA_WIDTH/8 is a power of two, >=4
//   BRAM_ADDR_WIDTH  12                     BRAM word-address width
//   BRAM_DEPTH       2**BRAM_ADDR_WIDTH     populated words; <= 2**BRAM_ADDR_WIDTH
//   BRAM_LATENCY     1                      cycles from bram_en to valid bram_rddata (1..3)
// PORTS
//   clk          in   1                clock
//   rstn         in   1                reset, synchronous, active-low
//   master       -    axi_lite_channel slave side of AXI-lite channel (AW/W/B/AR/R, ADDR_WIDTH/DATA_WIDTH)
//   bram_en      out  1                BRAM access enable
//   bram_we      out  DATA_WIDTH/8     byte write enables
//   bram_addr    out  BRAM_ADDR_WIDTH  word address
//   bram_wrdata  out  DATA_WIDTH       write data
//   bram_rddata  in   DATA_WIDTH       read data, valid BRAM_LATENCY cycles after bram_en with bram_we==0
// BEHAVIOUR
//   Reset (rstn==0 at a clk edge), values after that edge:
//     - aw_ready, w_ready, ar_ready, b_valid, r_valid, bram_en, bram_we = 0.
//     - b_resp, r_resp, r_data = 0.
//     - Return FIFO emptied, in-flight read tags dropped, arbiter priority set to READ.
//   Reset mid-operation discards outstanding reads and writes; no response is issued for them.
//   Address decode:
//     - word = addr[BRAM_ADDR_WIDTH+OFF-1:OFF], where OFF = log2(DATA_WIDTH/8).
//     - Low OFF address bits are ignored.
//     - Access is in range iff word < BRAM_DEPTH and all addr bits above BRAM_ADDR_WIDTH+OFF are 0.
//   Write:
//     - Eligible when aw_valid && w_valid && (!b_valid || b_ready).
//     - aw_ready = w_ready = write grant; AW and W are always taken in the same cycle.
//     - In the grant cycle T (combinational): bram_en=1, bram_we=w_strb, bram_addr=word, bram_wrdata=w_data.
//     - b_valid rises at T+1 with b_resp OKAY(00), and holds until b_ready.
//     - Out of range: bram_en=0, bram_we=0, b_resp SLVERR(10).
//     - w_strb==0: in range it is a BRAM cycle with bram_we=0 and OKAY; out of range it is still SLVERR.
//   Read:
//     - Return FIFO depth D = BRAM_LATENCY+1; pending = in-flight reads + FIFO count.
//     - Eligible when ar_valid && (pending - (r_valid && r_ready)) < D.
//     - In the grant cycle T: bram_en=1, bram_we=0, bram_addr=word.
//     - At T+BRAM_LATENCY the data is pushed into the FIFO; r_valid appears at T+BRAM_LATENCY+1.
//     - Out of range: no BRAM cycle; a tag carries data 0 / SLVERR through the same latency slot.
//     - Read responses are always returned in request order.
//   Arbitration (one BRAM op per cycle):
//     - Only one of read/write eligible: that one is granted.
//     - Both eligible: the side opposite the last grant wins; after reset that is READ.
//   Output timing: r_*, b_* and the FIFO are registered; ready signals come combinationally from state and valid.
//   Throughput: one access per cycle with ready held high; the credit check makes FIFO overflow impossible.
//   When bram_en==0, bram_addr, bram_wrdata and bram_we must be 0.
// TESTING
//   1. LAT=1; write 64'hDEADBEEF_CAFEF00D @0x10, strb FF -> same cycle en=1, we=FF, addr=2; b OKAY at T+1.
//      Then read @0x10 -> r_data matches, r_valid at T+2.
//   2. Then write 64'h0 @0x10 with strb 0F -> read returns 64'hDEADBEEF_00000000.
//   3. LAT=2, r_ready=1, 8 back-to-back reads -> ar_ready held 1; 8 beats on consecutive cycles starting at T0+3.
//   4. LAT=2, r_ready=0, ar_valid held -> exactly 3 accepted, then ar_ready=0.
//      Raise r_ready -> all 3 delivered in order, none lost.
//   5. aw/w/ar valid every cycle -> grants alternate R,W,R,W...; b and r counts are equal after 20 cycles.
//   6. BRAM_DEPTH=1000; read @8000 -> bram_en stays 0, r_resp SLVERR, r_data 0.
//      Drop rstn with 2 reads in flight -> no r_valid after release.

Source files
------------

// File: rtl/axi_lite_bram_ctrl_pipe.sv
// axi_lite_bram_ctrl_pipe
//   AXI-lite slave in front of a single-port BRAM whose read data arrives
//   BRAM_LATENCY (1..3) cycles after bram_en. Reads are pipelined through a
//   tag shift register into a small return FIFO. A read is granted only when
//   the FIFO has a guaranteed slot for it, so one access per cycle can be
//   sustained and the FIFO cannot overflow. Addresses outside BRAM_DEPTH get
//   SLVERR and never touch the BRAM.
//
// Ports
//   clk, rstn                   clock, synchronous active-low reset
//   aw_* / w_* / b_*            AXI-lite write address, write data, write response
//   ar_* / r_*                  AXI-lite read address, read data/response
//   bram_en, bram_we            BRAM enable and byte write enables
//   bram_addr, bram_wrdata      BRAM word address and write data
//   bram_rddata                 BRAM read data (valid BRAM_LATENCY cycles after bram_en)
//
// Arbiter states
//   state  | meaning
//   PRI_RD | read wins when both sides are eligible (state after reset)
//   PRI_WR | write wins when both sides are eligible

module axi_lite_bram_ctrl_pipe #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int BRAM_ADDR_WIDTH = 12,
  parameter int BRAM_DEPTH      = 2**BRAM_ADDR_WIDTH,
  parameter int BRAM_LATENCY    = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  // write address
  input  logic                       aw_valid,
  output logic                       aw_ready,
  input  logic [ADDR_WIDTH-1:0]      aw_addr,
  // write data
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [DATA_WIDTH-1:0]      w_data,
  input  logic [DATA_WIDTH/8-1:0]    w_strb,
  // write response
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [1:0]                 b_resp,
  // read address
  input  logic                       ar_valid,
  output logic                       ar_ready,
  input  logic [ADDR_WIDTH-1:0]      ar_addr,
  // read data
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [DATA_WIDTH-1:0]      r_data,
  output logic [1:0]                 r_resp,
  // BRAM
  output logic                       bram_en,
  output logic [DATA_WIDTH/8-1:0]    bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0]      bram_wrdata,
  input  logic [DATA_WIDTH-1:0]      bram_rddata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int HI     = BRAM_ADDR_WIDTH + OFF;
  localparam int D      = BRAM_LATENCY + 1;
  localparam int CNT_W  = $clog2(2 * D) + 1;

  localparam logic [BRAM_ADDR_WIDTH:0] DEPTH_L = (BRAM_ADDR_WIDTH + 1)'(BRAM_DEPTH);
  localparam logic [CNT_W-1:0]         D_L     = CNT_W'(D);
  localparam logic [1:0]               RESP_OKAY   = 2'b00;
  localparam logic [1:0]               RESP_SLVERR = 2'b10;

  typedef enum logic {PRI_RD = 1'b0, PRI_WR = 1'b1} pri_t;

  // Word index must be below BRAM_DEPTH and nothing may be set above the
  // BRAM word field.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] upper;
    upper = a >> HI;
    return (upper == '0) && ({1'b0, a[HI-1:OFF]} < DEPTH_L);
  endfunction

  pri_t pri_q, pri_d;

  logic                       wr_elig, rd_elig;
  logic                       wr_grant, rd_grant;
  logic                       wr_in, rd_in;
  logic [BRAM_ADDR_WIDTH-1:0] aw_word, ar_word;

  // read tag pipeline: bit i set means a read granted i+1 cycles ago
  logic [BRAM_LATENCY-1:0]    pipe_vld;
  logic [BRAM_LATENCY-1:0]    pipe_oor;

  // return FIFO as a shift register; entry 0 drives the R channel directly
  logic [D-1:0]               vld, nxt_vld;
  logic [DATA_WIDTH-1:0]      dat [D];
  logic [DATA_WIDTH-1:0]      nxt_dat [D];
  logic [1:0]                 rsp [D];
  logic [1:0]                 nxt_rsp [D];
  logic                       placed;

  logic                       push, pop;
  logic [DATA_WIDTH-1:0]      push_dat;
  logic [1:0]                 push_rsp;
  logic [CNT_W-1:0]           inflight, fifo_cnt, pending;

  assign aw_word = aw_addr[HI-1:OFF];
  assign ar_word = ar_addr[HI-1:OFF];
  assign wr_in   = in_range(aw_addr);
  assign rd_in   = in_range(ar_addr);

  // credit check: count every read that will land in the FIFO
  always_comb begin
    inflight = '0;
    fifo_cnt = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) inflight = inflight + CNT_W'(pipe_vld[i]);
    for (int i = 0; i < D; i++) fifo_cnt = fifo_cnt + CNT_W'(vld[i]);
    pending = inflight + fifo_cnt;
  end

  assign pop     = vld[0] && r_ready;
  assign wr_elig = rstn && aw_valid && w_valid && (!b_valid || b_ready);
  assign rd_elig = rstn && ar_valid && ((pending - CNT_W'(pop)) < D_L);

  // arbiter: state register
  always_ff @(posedge clk) begin
    if (!rstn) pri_q <= PRI_RD;
    else       pri_q <= pri_d;
  end

  // arbiter: next state, the loser of the last grant gets priority
  always_comb begin
    pri_d = pri_q;
    if (rd_grant)      pri_d = PRI_WR;
    else if (wr_grant) pri_d = PRI_RD;
  end

  // arbiter: grants
  always_comb begin
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (rd_elig && (!wr_elig || pri_q == PRI_RD)) rd_grant = 1'b1;
    else if (wr_elig)                             wr_grant = 1'b1;
  end

  assign aw_ready = wr_grant;
  assign w_ready  = wr_grant;
  assign ar_ready = rd_grant;

  // BRAM port; everything idles at zero when no BRAM cycle is issued
  always_comb begin
    bram_en     = 1'b0;
    bram_we     = '0;
    bram_addr   = '0;
    bram_wrdata = '0;
    if (wr_grant && wr_in) begin
      bram_en     = 1'b1;
      bram_we     = w_strb;
      bram_addr   = aw_word;
      bram_wrdata = w_data;
    end else if (rd_grant && rd_in) begin
      bram_en   = 1'b1;
      bram_addr = ar_word;
    end
  end

  // write response
  always_ff @(posedge clk) begin
    if (!rstn) begin
      b_valid <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else if (wr_grant) begin
      b_valid <= 1'b1;
      b_resp  <= wr_in ? RESP_OKAY : RESP_SLVERR;
    end else if (b_ready) begin
      b_valid <= 1'b0;
    end
  end

  // read tag pipeline; out-of-range reads ride along so ordering is kept
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_vld <= '0;
      pipe_oor <= '0;
    end else begin
      pipe_vld[0] <= rd_grant;
      pipe_oor[0] <= rd_grant && !rd_in;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_oor[i] <= pipe_oor[i-1];
      end
    end
  end

  assign push     = pipe_vld[BRAM_LATENCY-1];
  assign push_dat = pipe_oor[BRAM_LATENCY-1] ? '0 : bram_rddata;
  assign push_rsp = pipe_oor[BRAM_LATENCY-1] ? RESP_SLVERR : RESP_OKAY;

  // FIFO next state: shift on pop (vacated tail cleared so an empty FIFO
  // presents zero data), then push into the first free slot
  always_comb begin
    nxt_vld = vld;
    nxt_dat = dat;
    nxt_rsp = rsp;
    placed  = 1'b0;
    if (pop) begin
      for (int i = 0; i < D - 1; i++) begin
        nxt_vld[i] = vld[i+1];
        nxt_dat[i] = dat[i+1];
        nxt_rsp[i] = rsp[i+1];
      end
      nxt_vld[D-1] = 1'b0;
      nxt_dat[D-1] = '0;
      nxt_rsp[D-1] = '0;
    end
    if (push) begin
      for (int i = 0; i < D; i++) begin
        if (!placed && !nxt_vld[i]) begin
          nxt_vld[i] = 1'b1;
          nxt_dat[i] = push_dat;
          nxt_rsp[i] = push_rsp;
          placed     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld <= '0;
      for (int i = 0; i < D; i++) begin
        dat[i] <= '0;
        rsp[i] <= '0;
      end
    end else begin
      vld <= nxt_vld;
      for (int i = 0; i < D; i++) begin
        dat[i] <= nxt_dat[i];
        rsp[i] <= nxt_rsp[i];
      end
    end
  end

  assign r_valid = vld[0];
  assign r_data  = dat[0];
  assign r_resp  = rsp[0];

endmodule

// File: tb/tb_axi_lite_bram_ctrl_pipe.sv
// tb_axi_lite_bram_ctrl_pipe
//   Directed and randomized bench for axi_lite_bram_ctrl_pipe with a
//   2-cycle-latency BRAM model and 1000 populated words. A scoreboard keeps
//   the expected memory image indexed by AXI address and queues of expected
//   responses in request order.

module tb_axi_lite_bram_ctrl_pipe;

  localparam int LAT   = 2;
  localparam int DEPTH = 1000;
  localparam int BAW   = 10;

  logic        clk;
  logic        rstn;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic        r_valid, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        bram_en;
  logic [7:0]  bram_we;
  logic [BAW-1:0] bram_addr;
  logic [63:0] bram_wrdata;
  logic [63:0] bram_rddata;

  int n_checks = 0;
  int n_fail   = 0;
  int r_beats  = 0;
  int b_beats  = 0;

  axi_lite_bram_ctrl_pipe #(
    .ADDR_WIDTH(32), .DATA_WIDTH(64), .BRAM_ADDR_WIDTH(BAW),
    .BRAM_DEPTH(DEPTH), .BRAM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wrdata(bram_wrdata), .bram_rddata(bram_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // BRAM model: LAT-cycle read pipeline, garbage when not enabled
  logic [63:0] bram_mem  [1024];
  logic [63:0] bram_pipe [LAT];
  always @(posedge clk) begin
    if (bram_en) begin
      bram_pipe[0] <= bram_mem[bram_addr];
      for (int b = 0; b < 8; b++)
        if (bram_we[b]) bram_mem[bram_addr][8*b +: 8] <= bram_wrdata[8*b +: 8];
    end else begin
      bram_pipe[0] <= {$urandom, $urandom};
    end
    for (int i = 1; i < LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign bram_rddata = bram_pipe[LAT-1];

  // reference model: memory image keyed by AXI word, responses in order
  logic [63:0] ref_mem [DEPTH];
  logic [65:0] rq [$];
  logic [1:0]  bq [$];

  function automatic logic ok_addr(input logic [31:0] a);
    return (a >> 3) < DEPTH;
  endfunction

  always @(negedge clk) begin
    logic [65:0] er;
    logic [1:0]  eb;
    if (!rstn) begin
      rq.delete();
      bq.delete();
    end else begin
      if (!bram_en)
        chk("bram_idle_zero", 64'((|bram_we) || (|bram_addr) || (|bram_wrdata)), 64'd0);
      chk("single_grant", 64'(aw_ready && ar_ready), 64'd0);
      if (ar_valid && ar_ready)
        rq.push_back(ok_addr(ar_addr) ? {2'b00, ref_mem[ar_addr >> 3]} : {2'b10, 64'd0});
      if (aw_valid && aw_ready) begin
        chk("w_with_aw", 64'(w_ready), 64'd1);
        if (ok_addr(aw_addr)) begin
          for (int b = 0; b < 8; b++)
            if (w_strb[b]) ref_mem[aw_addr >> 3][8*b +: 8] = w_data[8*b +: 8];
          bq.push_back(2'b00);
        end else begin
          bq.push_back(2'b10);
        end
      end
      if (r_valid && r_ready) begin
        r_beats++;
        chk("r_expected", 64'(rq.size() != 0), 64'd1);
        if (rq.size() != 0) begin
          er = rq.pop_front();
          chk("r_data", r_data, er[63:0]);
          chk("r_resp", 64'(r_resp), 64'(er[65:64]));
        end
      end
      if (b_valid && b_ready) begin
        b_beats++;
        chk("b_expected", 64'(bq.size() != 0), 64'd1);
        if (bq.size() != 0) begin
          eb = bq.pop_front();
          chk("b_resp", 64'(b_resp), 64'(eb));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_txn(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                        output logic en, output logic [7:0] we, output logic [1:0] resp);
    logic got;
    got = 1'b0; en = 1'b0; we = '0; resp = 2'b11;
    aw_valid = 1'b1; w_valid = 1'b1; aw_addr = a; w_data = d; w_strb = s; b_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (aw_ready) begin got = 1'b1; en = bram_en; we = bram_we; break; end
      tick();
    end
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("wr_accept", 64'(got), 64'd1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_valid) begin got = 1'b1; resp = b_resp; break; end
      tick();
    end
    tick();
    chk("wr_bresp_seen", 64'(got), 64'd1);
  endtask

  task automatic rd_txn(input logic [31:0] a, output logic [63:0] d,
                        output logic [1:0] resp, output logic en);
    logic got;
    got = 1'b0; en = 1'b0; d = '0; resp = 2'b11;
    ar_valid = 1'b1; ar_addr = a; r_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ar_ready) begin got = 1'b1; en = bram_en; break; end
      tick();
    end
    tick();
    ar_valid = 1'b0;
    chk("rd_accept", 64'(got), 64'd1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_valid) begin got = 1'b1; d = r_data; resp = r_resp; break; end
      tick();
    end
    tick();
    chk("rd_return_seen", 64'(got), 64'd1);
  endtask

  initial begin
    logic        en;
    logic [7:0]  we;
    logic [1:0]  resp;
    logic [63:0] d;
    logic        last_rd, exp_rd;
    int          rb0, bb0;

    rstn = 1'b0;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    aw_addr = 32'h10; ar_addr = 32'h10; w_data = '0; w_strb = 8'hFF;
    b_ready = 1'b0; r_ready = 1'b0;
    repeat (3) tick();

    // reset state, ready held low even with valids up
    @(negedge clk);
    chk("rst_aw_ready", 64'(aw_ready), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_ar_ready", 64'(ar_ready), 64'd0);
    chk("rst_b_valid", 64'(b_valid), 64'd0);
    chk("rst_r_valid", 64'(r_valid), 64'd0);
    chk("rst_bram_en", 64'(bram_en), 64'd0);
    chk("rst_bram_we", 64'(bram_we), 64'd0);
    chk("rst_b_resp", 64'(b_resp), 64'd0);
    chk("rst_r_resp", 64'(r_resp), 64'd0);
    chk("rst_r_data", r_data, 64'd0);
    tick();
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // preload every populated word through the DUT
    for (int i = 0; i < DEPTH; i++) wr_txn(32'(i * 8), {$urandom, $urandom}, 8'hFF, en, we, resp);

    // full-strobe write with same-cycle BRAM port check, response one cycle later
    aw_valid = 1'b1; w_valid = 1'b1; aw_addr = 32'h10;
    w_data = 64'hDEADBEEF_CAFEF00D; w_strb = 8'hFF; b_ready = 1'b1;
    @(negedge clk);
    chk("t1_aw_ready", 64'(aw_ready), 64'd1);
    chk("t1_w_ready", 64'(w_ready), 64'd1);
    chk("t1_bram_en", 64'(bram_en), 64'd1);
    chk("t1_bram_we", 64'(bram_we), 64'hFF);
    chk("t1_bram_addr", 64'(bram_addr), 64'd2);
    chk("t1_bram_wrdata", bram_wrdata, 64'hDEADBEEF_CAFEF00D);
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    chk("t1_b_valid", 64'(b_valid), 64'd1);
    chk("t1_b_resp", 64'(b_resp), 64'd0);
    tick();

    // read back: r_valid exactly LAT+1 cycles after grant
    ar_valid = 1'b1; ar_addr = 32'h10; r_ready = 1'b1;
    @(negedge clk);
    chk("t1_ar_ready", 64'(ar_ready), 64'd1);
    chk("t1_rd_bram_en", 64'(bram_en), 64'd1);
    chk("t1_rd_bram_we", 64'(bram_we), 64'd0);
    chk("t1_rd_bram_addr", 64'(bram_addr), 64'd2);
    tick();
    ar_valid = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk("t1_r_valid_timing", 64'(r_valid), 64'(k == LAT + 1));
      if (k == LAT + 1) chk("t1_r_data", r_data, 64'hDEADBEEF_CAFEF00D);
      tick();
    end

    // partial strobe
    wr_txn(32'h10, 64'h0, 8'h0F, en, we, resp);
    chk("t2_bresp", 64'(resp), 64'd0);
    rd_txn(32'h10, d, resp, en);
    chk("t2_merged", d, 64'hDEADBEEF_00000000);

    // 8 back-to-back reads, beats on consecutive cycles starting T0+LAT+1
    r_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      ar_valid = (k < 8);
      ar_addr  = $urandom_range(0, DEPTH * 8 - 1);
      @(negedge clk);
      chk("t3_ar_ready", 64'(ar_ready), 64'(k < 8));
      chk("t3_r_valid", 64'(r_valid), 64'((k >= LAT + 1) && (k < LAT + 9)));
      tick();
    end
    ar_valid = 1'b0;

    // back-pressure: credits limit acceptance to LAT+1 reads
    r_ready = 1'b0;
    rb0 = r_beats;
    for (int k = 0; k < 8; k++) begin
      ar_valid = 1'b1;
      if (k == 0 || ar_ready) ar_addr = $urandom_range(0, DEPTH * 8 - 1);
      @(negedge clk);
      chk("t4_ar_ready", 64'(ar_ready), 64'(k < LAT + 1));
      tick();
    end
    ar_valid = 1'b0;
    r_ready = 1'b1;
    repeat (8) tick();
    chk("t4_beats", 64'(r_beats - rb0), 64'(LAT + 1));

    // all valids up: grants alternate, starting opposite the last grant (read)
    rb0 = r_beats; bb0 = b_beats;
    last_rd = 1'b1;
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
    aw_addr = $urandom_range(0, 8191); w_data = {$urandom, $urandom}; w_strb = 8'($urandom);
    ar_addr = $urandom_range(0, 8191);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp_rd = !last_rd;
      chk("t5_ar_grant", 64'(ar_ready), 64'(exp_rd));
      chk("t5_aw_grant", 64'(aw_ready), 64'(!exp_rd));
      last_rd = exp_rd;
      tick();
      if (exp_rd) ar_addr = $urandom_range(0, 8191);
      else begin
        aw_addr = $urandom_range(0, 8191); w_data = {$urandom, $urandom}; w_strb = 8'($urandom);
      end
    end
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    repeat (8) tick();
    chk("t5_r_count", 64'(r_beats - rb0), 64'd10);
    chk("t5_b_count", 64'(b_beats - bb0), 64'd10);

    // range boundaries
    rd_txn(32'd8000, d, resp, en);
    chk("t6_oor_rd_en", 64'(en), 64'd0);
    chk("t6_oor_rd_resp", 64'(resp), 64'd2);
    chk("t6_oor_rd_data", d, 64'd0);
    rd_txn(32'd7999, d, resp, en);
    chk("t6_last_word_en", 64'(en), 64'd1);
    chk("t6_last_word_resp", 64'(resp), 64'd0);
    rd_txn(32'h2010, d, resp, en);
    chk("t6_high_bit_en", 64'(en), 64'd0);
    chk("t6_high_bit_resp", 64'(resp), 64'd2);
    wr_txn(32'd8000, 64'h1234, 8'hFF, en, we, resp);
    chk("t6_oor_wr_en", 64'(en), 64'd0);
    chk("t6_oor_wr_we", 64'(we), 64'd0);
    chk("t6_oor_wr_resp", 64'(resp), 64'd2);
    wr_txn(32'h18, 64'h5555, 8'h00, en, we, resp);
    chk("t6_zero_strb_en", 64'(en), 64'd1);
    chk("t6_zero_strb_we", 64'(we), 64'd0);
    chk("t6_zero_strb_resp", 64'(resp), 64'd0);
    wr_txn(32'd8192, 64'h0, 8'h00, en, we, resp);
    chk("t6_oor_zero_strb_resp", 64'(resp), 64'd2);

    // reset with two reads in flight: nothing comes back
    r_ready = 1'b1;
    ar_valid = 1'b1; ar_addr = 32'h10;
    tick();
    ar_addr = 32'h20;
    tick();
    ar_valid = 1'b0;
    rstn = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) begin
      if (k == 1) rstn = 1'b1;
      @(negedge clk);
      chk("t6_no_r_after_reset", 64'(r_valid), 64'd0);
      tick();
    end

    // priority returns to read after reset
    aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1;
    aw_addr = 32'h40; w_data = 64'hA5A5; w_strb = 8'hFF; ar_addr = 32'h48;
    @(negedge clk);
    chk("rst_pri_read", 64'(ar_ready), 64'd1);
    chk("rst_pri_no_write", 64'(aw_ready), 64'd0);
    tick();
    ar_valid = 1'b0;
    @(negedge clk);
    chk("rst_pri_write_next", 64'(aw_ready), 64'd1);
    tick();
    aw_valid = 1'b0; w_valid = 1'b0;
    repeat (8) tick();

    chk("final_rq_empty", 64'(rq.size()), 64'd0);
    chk("final_bq_empty", 64'(bq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
